// File: rtl/phase_frame_loader_pkg.sv
// phase_frame_pkg: shared types for phase_frame_loader.
//   cmd_e   - command byte encodings of the 4-byte command word
//   err_e   - err_code encodings (first error cause)
//   state_e - loader FSM states
//   WORD_BYTES - bytes per command word (cmd, ch_hi, ch_lo, arg)
package phase_frame_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [7:0] {
    NOP       = 8'h00,
    SET_PHASE = 8'h01,
    SET_EN    = 8'h02,
    COMMIT    = 8'h03,
    SET_ALL   = 8'h04
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CMD     = 2'd1,
    ERR_CH      = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    FETCH       = 2'd0,
    EXEC        = 2'd1,
    COMMIT_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/phase_frame_loader_bank.sv
// phase_bank_dp: shadow/active phase and enable banks.
//   clk, rst_n   - clock, async active-low reset
//   wr_phase     - write wr_data into shadow phase of channel wr_ch
//   wr_en        - write wr_bit into shadow enable of channel wr_ch
//   wr_all       - broadcast wr_data into every shadow phase
//   commit       - copy whole shadow bank to active bank in one cycle
//   phases       - active phase bank (registered)
//   pwm_en       - active enable bank (registered)
module phase_bank_dp #(
  parameter int unsigned NUM_CHANNELS = 256,
  parameter int unsigned PHASE_W      = 8,
  parameter int unsigned CH_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_phase,
  input  logic               wr_en,
  input  logic               wr_all,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [PHASE_W-1:0] wr_data,
  input  logic               wr_bit,
  input  logic               commit,
  output logic [PHASE_W-1:0] phases [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] pwm_en
);

  logic [PHASE_W-1:0]      shadow_phase [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] shadow_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        shadow_phase[i] <= '0;
        phases[i]       <= '0;
      end
      shadow_en <= '1;
      pwm_en    <= '1;
    end else begin
      if (wr_all) begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          shadow_phase[i] <= wr_data;
        end
      end
      if (wr_phase) begin
        shadow_phase[wr_ch] <= wr_data;
      end
      if (wr_en) begin
        shadow_en[wr_ch] <= wr_bit;
      end
      if (commit) begin
        phases <= shadow_phase;
        pwm_en <= shadow_en;
      end
    end
  end

endmodule

// File: rtl/phase_frame_loader.sv
// phase_frame_loader: assembles 4-byte command words from the RX FIFO and
// loads a shadow phase/enable bank, committing it atomically to the active
// bank.
//   clk, rst_n     - sys_clk, async active-low reset
//   rxfifo_*       - RX FIFO read interface (valid 1 cycle after rd)
//   commit_strobe  - PWM period-start pulse (used by the sync-commit build)
//   error_clr      - clears read_error / err_code
//   phases, pwm_en - active banks
//   frame_cnt      - number of commits, wraps at 2^16
//   read_error, err_code - sticky error flag and first error cause
// Build option: define PHASE_FRAME_LOADER_SYNC_COMMIT_EN to defer COMMIT to
// the next commit_strobe (state COMMIT_WAIT); otherwise COMMIT copies in EXEC.
module phase_frame_loader
  import phase_frame_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 256,
  parameter int unsigned PHASE_W        = 8,
  parameter int unsigned RX_FIFO_LOAD_W = 11,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rxfifo_data,
  input  logic                      rxfifo_valid,
  input  logic                      rxfifo_empty,
  input  logic [RX_FIFO_LOAD_W-1:0] rxfifo_load,
  output logic                      rxfifo_rd,
  input  logic                      commit_strobe,
  input  logic                      error_clr,
  output logic [PHASE_W-1:0]        phases [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]   pwm_en,
  output logic [15:0]               frame_cnt,
  output logic                      read_error,
  output logic [1:0]                err_code
);

  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  state_e          state, state_next;
  logic [1:0]      byte_idx;
  logic [7:0]      word_buf [WORD_BYTES];
  logic            rd_pending;
  logic [TO_W-1:0] idle_cnt;

  logic [7:0]  cmd;
  logic [15:0] ch;
  logic [7:0]  arg;
  logic        ch_ok;

  logic rd_issue, timeout_hit;
  logic do_phase, do_en, do_all, do_commit;
  logic err_event;
  err_e err_cause;

  logic unused_ok;
  assign unused_ok = ^{rxfifo_load, arg, commit_strobe};

  assign cmd   = word_buf[0];
  assign ch    = {word_buf[1], word_buf[2]};
  assign arg   = word_buf[3];
  assign ch_ok = (32'(ch) < NUM_CHANNELS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    rd_issue    = 1'b0;
    timeout_hit = 1'b0;
    do_phase    = 1'b0;
    do_en       = 1'b0;
    do_all      = 1'b0;
    do_commit   = 1'b0;
    err_event   = 1'b0;
    err_cause   = ERR_NONE;
    case (state)
      FETCH: begin
        rd_issue = !rxfifo_empty && !rd_pending;
        if (rxfifo_valid && byte_idx == 2'(WORD_BYTES - 1)) begin
          state_next = EXEC;
        end else if (!rxfifo_valid && byte_idx != '0 &&
                     idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          err_event   = 1'b1;
          err_cause   = ERR_TIMEOUT;
        end
      end
      EXEC: begin
        state_next = FETCH;
        case (cmd)
          NOP: ;
          SET_PHASE: begin
            if (ch_ok) begin
              do_phase = 1'b1;
            end else begin
              err_event = 1'b1;
              err_cause = ERR_CH;
            end
          end
          SET_EN: begin
            if (ch_ok) begin
              do_en = 1'b1;
            end else begin
              err_event = 1'b1;
              err_cause = ERR_CH;
            end
          end
          COMMIT: begin
`ifdef PHASE_FRAME_LOADER_SYNC_COMMIT_EN
            state_next = COMMIT_WAIT;
`else
            do_commit = 1'b1;
`endif
          end
          SET_ALL: do_all = 1'b1;
          default: begin
            err_event = 1'b1;
            err_cause = ERR_CMD;
          end
        endcase
      end
      COMMIT_WAIT: begin
`ifdef PHASE_FRAME_LOADER_SYNC_COMMIT_EN
        // A strobe during EXEC is not seen here: only strobes in this state count.
        if (commit_strobe) begin
          do_commit  = 1'b1;
          state_next = FETCH;
        end
`else
        state_next = FETCH;
`endif
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxfifo_rd  <= 1'b0;
      rd_pending <= 1'b0;
      byte_idx   <= '0;
      idle_cnt   <= '0;
      frame_cnt  <= '0;
      read_error <= 1'b0;
      err_code   <= ERR_NONE;
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        word_buf[i] <= '0;
      end
    end else begin
      rxfifo_rd <= rd_issue;
      // Pending covers the strobe cycle and the following data cycle.
      if (rd_issue) begin
        rd_pending <= 1'b1;
      end else if (rxfifo_valid) begin
        rd_pending <= 1'b0;
      end

      if (state == FETCH) begin
        if (rxfifo_valid) begin
          word_buf[byte_idx] <= rxfifo_data;
          byte_idx           <= byte_idx + 2'd1;
        end else if (timeout_hit) begin
          byte_idx <= '0;
        end
      end

      if (state != FETCH || rxfifo_valid || byte_idx == '0 || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end

      if (do_commit) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      // A new error in the same cycle as error_clr takes precedence.
      if (err_event) begin
        if (!read_error || error_clr) begin
          read_error <= 1'b1;
          err_code   <= err_cause;
        end
      end else if (error_clr) begin
        read_error <= 1'b0;
        err_code   <= ERR_NONE;
      end
    end
  end

  phase_bank_dp #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PHASE_W      (PHASE_W),
    .CH_W         (CH_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_phase (do_phase),
    .wr_en    (do_en),
    .wr_all   (do_all),
    .wr_ch    (ch[CH_W-1:0]),
    .wr_data  (arg[PHASE_W-1:0]),
    .wr_bit   (arg[0]),
    .commit   (do_commit),
    .phases   (phases),
    .pwm_en   (pwm_en)
  );

endmodule

// File: tb/tb_phase_frame_loader.sv
// Self-checking bench for phase_frame_loader: RX FIFO model, reference bank
// model and a commit scoreboard (expected frame_cnt + bank hash per commit).
module tb_phase_frame_loader;
  import phase_frame_pkg::*;

  localparam int unsigned NCH = 256;
  localparam int unsigned PW  = 8;
  localparam int unsigned T   = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rxfifo_data;
  logic          rxfifo_valid;
  logic          rxfifo_empty;
  logic [10:0]   rxfifo_load;
  logic          rxfifo_rd;
  logic          commit_strobe;
  logic          error_clr;
  logic [PW-1:0] phases [NCH];
  logic [NCH-1:0] pwm_en;
  logic [15:0]   frame_cnt;
  logic          read_error;
  logic [1:0]    err_code;

  phase_frame_loader #(
    .NUM_CHANNELS   (NCH),
    .PHASE_W        (PW),
    .RX_FIFO_LOAD_W (11),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxfifo_data   (rxfifo_data),
    .rxfifo_valid  (rxfifo_valid),
    .rxfifo_empty  (rxfifo_empty),
    .rxfifo_load   (rxfifo_load),
    .rxfifo_rd     (rxfifo_rd),
    .commit_strobe (commit_strobe),
    .error_clr     (error_clr),
    .phases        (phases),
    .pwm_en        (pwm_en),
    .frame_cnt     (frame_cnt),
    .read_error    (read_error),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [8:0]  fifo_q [$];          // bit 8 marks the last byte of a COMMIT word
  logic        rd_seen = 1'b0;
  logic [8:0]  held = '0;
  int unsigned last_valid_edge = 0;
  int unsigned commit_mark_q [$];   // clock edge on which a COMMIT word's last byte is sampled

  initial begin
    rxfifo_valid = 1'b0;
    rxfifo_data  = '0;
    rxfifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rxfifo_valid = 1'b0;
        rd_seen      = 1'b0;
      end else begin
        rxfifo_valid = rd_seen;
        rxfifo_data  = held[7:0];
        if (rd_seen) begin
          last_valid_edge = cyc + 1;
          if (held[8]) commit_mark_q.push_back(cyc + 1);
        end
        rd_seen = 1'b0;
        if (rxfifo_rd) begin
          check_eq("rd_nonempty", 32'(fifo_q.size() > 0), 1);
          if (fifo_q.size() > 0) begin
            held    = fifo_q.pop_front();
            rd_seen = 1'b1;
          end
        end
      end
      rxfifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [15:0] fc;
    int unsigned h;
  } sb_t;

  logic [PW-1:0]  m_sh  [NCH];
  logic [PW-1:0]  m_act [NCH];
  logic [NCH-1:0] m_en_sh, m_en_act;
  logic [15:0]    m_fc;
  sb_t            sb_q [$];

  function automatic int unsigned bank_hash(input logic [PW-1:0] p [NCH], input logic [NCH-1:0] e);
    int unsigned h;
    h = 32'h811c9dc5;
    for (int i = 0; i < NCH; i++) begin
      h = (h ^ {23'd0, e[i], p[i]}) * 32'h01000193;
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_en_sh  = '1;
    m_en_act = '1;
    m_fc     = '0;
  endtask

  task automatic push_word(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] a);
    logic [15:0] chn;
    sb_t e;
    chn = {hi, lo};
    fifo_q.push_back({1'b0, c});
    fifo_q.push_back({1'b0, hi});
    fifo_q.push_back({1'b0, lo});
    fifo_q.push_back({(c == 8'h03), a});
    case (c)
      8'h01: if (chn < 16'(NCH)) m_sh[chn[7:0]] = a;
      8'h02: if (chn < 16'(NCH)) m_en_sh[chn[7:0]] = a[0];
      8'h03: begin
        m_act    = m_sh;
        m_en_act = m_en_sh;
        m_fc     = m_fc + 16'd1;
        e.fc     = m_fc;
        e.h      = bank_hash(m_act, m_en_act);
        sb_q.push_back(e);
      end
      8'h04: for (int i = 0; i < NCH; i++) m_sh[i] = a;
      default: ;
    endcase
  endtask

  logic [15:0] last_fc = '0;
  initial begin
    sb_t e;
    int unsigned m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_fc = '0;
      end else if (frame_cnt != last_fc) begin
        check_eq("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("frame_cnt", 32'(frame_cnt), 32'(e.fc));
          check_eq("bank_hash", bank_hash(phases, pwm_en), e.h);
        end
`ifndef PHASE_FRAME_LOADER_SYNC_COMMIT_EN
        check_eq("commit_mark", 32'(commit_mark_q.size() > 0), 1);
        if (commit_mark_q.size() > 0) begin
          m = commit_mark_q.pop_front();
          check_eq("commit_latency", cyc, m + 1);
        end
`endif
        last_fc = frame_cnt;
      end
    end
  end

  // Periodic strobes so commits complete in the sync-commit build.
  logic auto_strobe = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (auto_strobe) commit_strobe = (cyc % 16 == 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int unsigned k = 0;
    while ((fifo_q.size() != 0 || rd_seen || rxfifo_valid) && k < 2000) begin
      tick(1);
      k++;
    end
    check_eq("drain_done", 32'(fifo_q.size()), 0);
    tick(4);
  endtask

  task automatic wait_frames(input logic [15:0] target);
    int unsigned k = 0;
    while (frame_cnt != target && k < 3000) begin
      tick(1);
      k++;
    end
    check_eq("frame_reached", 32'(frame_cnt), 32'(target));
    tick(1);
  endtask

  task automatic clear_env();
    fifo_q.delete();
    sb_q.delete();
    commit_mark_q.delete();
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned m;
    int unsigned k;
    error_clr     = 1'b0;
    commit_strobe = 1'b0;
    rxfifo_load   = '0;
    rst_n         = 1'b0;
    clear_env();
    tick(3);
    rst_n = 1'b1;
`ifdef PHASE_FRAME_LOADER_SYNC_COMMIT_EN
    auto_strobe = 1'b1;
`endif
    tick(1);

    // Reset state
    check_eq("rst_rd", 32'(rxfifo_rd), 0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("rst_read_error", 32'(read_error), 0);
    check_eq("rst_err_code", 32'(err_code), 0);
    check_eq("rst_bank", bank_hash(phases, pwm_en), bank_hash(m_act, m_en_act));

    // SET_PHASE ch5 + COMMIT
    push_word(8'h01, 8'h00, 8'h05, 8'h7F);
    push_word(8'h03, 8'h00, 8'h00, 8'h00);
    wait_frames(16'd1);
    check_eq("t1_ph5", 32'(phases[5]), 32'h7F);
    check_eq("t1_ph6", 32'(phases[6]), 32'h00);

    // Shadow write stays invisible until COMMIT
    push_word(8'h01, 8'h00, 8'h0A, 8'h33);
    tick(100);
    check_eq("t2_ph10_pre", 32'(phases[10]), 32'h00);
    push_word(8'h03, 8'h00, 8'h00, 8'h00);
    wait_frames(16'd2);
    check_eq("t2_ph10_post", 32'(phases[10]), 32'h33);

    // Out-of-range channel, then bad command keeps first cause, then clear
    push_word(8'h01, 8'h01, 8'h00, 8'h11);
    wait_drain();
    check_eq("t3_read_error", 32'(read_error), 1);
    check_eq("t3_err_code_ch", 32'(err_code), 32'(ERR_CH));
    push_word(8'h09, 8'h00, 8'h00, 8'h00);
    wait_drain();
    check_eq("t3_err_code_kept", 32'(err_code), 32'(ERR_CH));
    error_clr = 1'b1;
    tick(1);
    error_clr = 1'b0;
    check_eq("t3_clr_read_error", 32'(read_error), 0);
    check_eq("t3_clr_err_code", 32'(err_code), 0);
    push_word(8'h03, 8'h00, 8'h00, 8'h00);
    wait_frames(16'd3);
    check_eq("t3_ph0_untouched", 32'(phases[0]), 32'h00);

    // Partial word timeout
    fifo_q.push_back(9'h001);
    fifo_q.push_back(9'h000);
    k = 0;
    while ((fifo_q.size() != 0 || rd_seen || rxfifo_valid) && k < 500) begin
      tick(1);
      k++;
    end
    check_eq("t4_bytes_taken", 32'(fifo_q.size()), 0);
    m = last_valid_edge;
    k = 0;
    while (cyc < m + T - 1 && k < 500) begin
      tick(1);
      k++;
    end
    check_eq("t4_pre_timeout", 32'(read_error), 0);
    tick(1);
    check_eq("t4_timeout_flag", 32'(read_error), 1);
    check_eq("t4_timeout_code", 32'(err_code), 32'(ERR_TIMEOUT));
    push_word(8'h02, 8'h00, 8'h03, 8'h00);
    push_word(8'h03, 8'h00, 8'h00, 8'h00);
    wait_frames(16'd4);
    check_eq("t4_en3", 32'(pwm_en[3]), 0);
    check_eq("t4_en2", 32'(pwm_en[2]), 1);

`ifdef PHASE_FRAME_LOADER_SYNC_COMMIT_EN
    // Commit waits for a later strobe; no reads meanwhile
    auto_strobe = 1'b0;
    tick(1);
    commit_strobe = 1'b0;
    commit_mark_q.delete();
    push_word(8'h04, 8'h00, 8'h00, 8'h40);
    push_word(8'h03, 8'h00, 8'h00, 8'h00);
    push_word(8'h01, 8'h00, 8'h01, 8'h22);
    k = 0;
    while (commit_mark_q.size() == 0 && k < 500) begin
      tick(1);
      k++;
    end
    check_eq("t5_commit_seen", 32'(commit_mark_q.size() > 0), 1);
    m = (commit_mark_q.size() > 0) ? commit_mark_q[0] : cyc;
    k = 0;
    while (cyc < m && k < 500) begin
      tick(1);
      k++;
    end
    commit_strobe = 1'b1;   // coincides with EXEC of COMMIT: must not count
    tick(1);
    commit_strobe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_eq("t5_wait_rd", 32'(rxfifo_rd), 0);
      check_eq("t5_wait_ph5", 32'(phases[5]), 32'h7F);
      tick(1);
    end
    commit_strobe = 1'b1;
    tick(1);
    commit_strobe = 1'b0;
    check_eq("t5_ph0", 32'(phases[0]), 32'h40);
    check_eq("t5_ph255", 32'(phases[255]), 32'h40);
    wait_drain();
    check_eq("t5_ph1_shadow_only", 32'(phases[1]), 32'h40);
    auto_strobe = 1'b1;
`else
    // commit_strobe is ignored; SET_ALL lands only on COMMIT
    push_word(8'h04, 8'h00, 8'h00, 8'h40);
    wait_drain();
    commit_strobe = 1'b1;
    tick(1);
    commit_strobe = 1'b0;
    tick(3);
    check_eq("t5_strobe_ignored", 32'(phases[5]), 32'h7F);
    check_eq("t5_frame_unchanged", 32'(frame_cnt), 4);
    push_word(8'h03, 8'h00, 8'h00, 8'h00);
    wait_frames(16'd5);
    check_eq("t5_ph0", 32'(phases[0]), 32'h40);
    check_eq("t5_ph255", 32'(phases[255]), 32'h40);
`endif

    // Reset mid-word after 3 bytes
    fifo_q.push_back(9'h001);
    fifo_q.push_back(9'h000);
    fifo_q.push_back(9'h005);
    k = 0;
    while ((fifo_q.size() != 0 || rd_seen || rxfifo_valid) && k < 500) begin
      tick(1);
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ph5", 32'(phases[5]), 0);
    check_eq("t6_rst_ph0", 32'(phases[0]), 0);
    check_eq("t6_rst_en_all", 32'(&pwm_en), 1);
    check_eq("t6_rst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("t6_rst_rd", 32'(rxfifo_rd), 0);
    check_eq("t6_rst_read_error", 32'(read_error), 0);
    check_eq("t6_rst_err_code", 32'(err_code), 0);
    clear_env();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    push_word(8'h01, 8'h00, 8'h07, 8'h5A);
    push_word(8'h03, 8'h00, 8'h00, 8'h00);
    wait_frames(16'd1);
    check_eq("t6_ph7", 32'(phases[7]), 32'h5A);
    check_eq("t6_ph5", 32'(phases[5]), 32'h00);
    check_eq("t6_no_error", 32'(read_error), 0);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
